// File: rtl/macro_arbiter_rr_onehot.sv
// Round-robin arbiter with registered one-hot grant, binary index and valid.
// Grant is held until ack; a locked ack keeps the grant for burst transfers.
module macro_arbiter_rr_onehot #(
    parameter int OUTPUT_WIDTH = 4,
    parameter int INPUT_WIDTH  = 1 << OUTPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [INPUT_WIDTH-1:0]  req,
    input  logic [INPUT_WIDTH-1:0]  lock,
    input  logic                    ack,
    output logic [INPUT_WIDTH-1:0]  grant,
    output logic [OUTPUT_WIDTH-1:0] grant_idx,
    output logic                    grant_valid
);

    localparam int N = INPUT_WIDTH;
    localparam int W = OUTPUT_WIDTH;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t       state;
    logic [W-1:0] ptr;

    // Returns {found, index} of the first set bit at or after base, wrapping.
    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    function automatic logic [W:0] pick(
        input logic [N-1:0] r,
        input logic [W-1:0] base
    );
        logic [W:0]   res;
        logic [W-1:0] k;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = base + W'(i);
            if (r[k]) begin
                res = {1'b1, k};
            end
        end
        return res;
    endfunction

    logic [W-1:0] next_ptr;
    logic [W:0]   win_ptr;
    logic [W:0]   win_nxt;

    assign next_ptr = grant_idx + W'(1);
    assign win_ptr  = pick(req, ptr);
    assign win_nxt  = pick(req, next_ptr);

    logic         do_load;
    logic         do_clear;
    logic         do_adv;
    logic [W-1:0] load_idx;

    always_comb begin
        do_load  = 1'b0;
        do_clear = 1'b0;
        do_adv   = 1'b0;
        load_idx = win_ptr[W-1:0];
        unique case (state)
            IDLE: begin
                do_load = win_ptr[W];
            end
            GRANT: begin
                if (ack && !lock[grant_idx]) begin
                    do_adv   = 1'b1;
                    load_idx = win_nxt[W-1:0];
                    do_load  = win_nxt[W];
                    do_clear = !win_nxt[W];
                end else if (!ack && !req[grant_idx]) begin
                    do_load  = win_ptr[W];
                    do_clear = !win_ptr[W];
                end
            end
            default: begin
                do_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            if (do_adv) begin
                ptr <= next_ptr;
            end
            if (do_load) begin
                state       <= GRANT;
                grant       <= N'(1) << load_idx;
                grant_idx   <= load_idx;
                grant_valid <= 1'b1;
            end else if (do_clear) begin
                state       <= IDLE;
                grant       <= '0;
                grant_idx   <= '0;
                grant_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_macro_arbiter_rr_onehot.sv
// Randomised and directed bench for macro_arbiter_rr_onehot.
// Outputs are compared each cycle against an integer-level model.
module tb_macro_arbiter_rr_onehot;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk;
    logic         resetn;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic         ack;
    logic [N-1:0] grant;
    logic [W-1:0] grant_idx;
    logic         grant_valid;

    macro_arbiter_rr_onehot #(
        .OUTPUT_WIDTH(W),
        .INPUT_WIDTH (N)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .lock       (lock),
        .ack        (ack),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    int m_ptr;
    int m_g;
    bit m_v;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int scan(input logic [N-1:0] r, input int base);
        for (int i = 0; i < N; i++) begin
            if (r[(base + i) % N]) return (base + i) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (!resetn) begin
            m_ptr = 0;
            m_g   = 0;
            m_v   = 0;
        end else if (!m_v) begin
            w = scan(req, m_ptr);
            if (w >= 0) begin
                m_v = 1;
                m_g = w;
            end
        end else if (ack && lock[m_g]) begin
            m_v = 1;
        end else if (ack) begin
            m_ptr = (m_g + 1) % N;
            w = scan(req, m_ptr);
            if (w >= 0) m_g = w;
            else begin
                m_v = 0;
                m_g = 0;
            end
        end else if (!req[m_g]) begin
            w = scan(req, m_ptr);
            if (w >= 0) m_g = w;
            else begin
                m_v = 0;
                m_g = 0;
            end
        end
    endtask

    task automatic cycle();
        logic [31:0] eg;
        model_step();
        @(posedge clk);
        #1;
        eg = m_v ? (32'd1 << m_g) : 32'd0;
        chk("grant", 32'(grant), eg);
        chk("idx", 32'(grant_idx), 32'(m_g));
        chk("valid", 32'(grant_valid), 32'(m_v));
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        m_ptr  = 0;
        m_g    = 0;
        m_v    = 0;
        resetn = 1'b1;
        req    = '0;
        lock   = '0;
        ack    = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_valid", 32'(grant_valid), 32'd0);
        cycle();
        resetn = 1'b1;
        cycle();
        chk("rst_idle", 32'({grant, grant_idx, grant_valid}), 32'd0);

        req = 16'h0001;
        cycle();
        chk("first_grant", 32'(grant), 32'h0001);

        req = 16'hFFFF;
        ack = 1'b1;
        for (int i = 0; i < N; i++) begin
            cycle();
            chk("rotate_idx", 32'(grant_idx), 32'((i + 1) % N));
            chk("rotate_valid", 32'(grant_valid), 32'd1);
        end

        req = 16'h4000;
        cycle();
        chk("to14", 32'(grant_idx), 32'd14);
        req = 16'h8001;
        cycle();
        chk("wrap15", 32'(grant_idx), 32'd15);
        cycle();
        chk("wrap0", 32'(grant_idx), 32'd0);
        cycle();
        chk("skip15", 32'(grant_idx), 32'd15);
        req = '0;
        cycle();
        chk("drain", 32'(grant_valid), 32'd0);

        ack = 1'b0;
        req = 16'h0006;
        cycle();
        chk("lock_start", 32'(grant_idx), 32'd1);
        lock = 16'h0002;
        ack  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("lock_hold", 32'(grant_idx), 32'd1);
        end
        lock = '0;
        cycle();
        chk("lock_release", 32'(grant_idx), 32'd2);
        req = '0;
        cycle();
        chk("lock_idle", 32'(grant_valid), 32'd0);

        ack = 1'b0;
        req = 16'h0018;
        cycle();
        chk("wd_start", 32'(grant_idx), 32'd3);
        req = 16'h0010;
        cycle();
        chk("wd_move", 32'(grant_idx), 32'd4);
        req = 16'h0028;
        cycle();
        chk("wd_ptr_kept", 32'(grant_idx), 32'd3);
        req = '0;
        cycle();
        chk("wd_idle", 32'(grant_valid), 32'd0);

        req = 16'h0200;
        cycle();
        chk("pre_rst9", 32'(grant_idx), 32'd9);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst", 32'({grant, grant_idx, grant_valid}), 32'd0);
        cycle();
        resetn = 1'b1;
        req    = 16'h0201;
        cycle();
        chk("post_rst", 32'(grant_idx), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 99) != 0);
            case ($urandom_range(0, 3))
                0: req = N'($urandom);
                1: req = N'($urandom & $urandom);
                2: req = N'($urandom & $urandom & $urandom);
                default: req = (req == '0) ? N'($urandom) : req;
            endcase
            lock = N'($urandom & $urandom);
            ack  = $urandom_range(0, 2) != 0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
